// File: rtl/ram_port_arbiter.sv
// Single-port RAM arbiter: one host (fixed priority) and NUM_CORES cores (round-robin),
// one access at a time through an IDLE/ACCESS/WAIT/DONE sequencer with registered outputs.
module ram_port_arbiter #(
  parameter int NUM_CORES = 2,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        host_lock,
  input  logic                        host_req,
  input  logic                        host_we,
  input  logic [ADDR_W-1:0]           host_addr,
  input  logic [DATA_W-1:0]           host_wdata,
  output logic                        host_ack,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_we,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  output logic [NUM_CORES-1:0]        core_ack,
  output logic [DATA_W-1:0]           rdata,
  output logic                        ram_en,
  output logic                        ram_we,
  output logic [ADDR_W-1:0]           ram_addr,
  output logic [DATA_W-1:0]           ram_wdata,
  input  logic [DATA_W-1:0]           ram_rdata,
  output logic                        busy
);

  localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        last_q, last_d;
  logic [CW-1:0]        gnt_id_q, gnt_id_d;
  logic                 gnt_host_q, gnt_host_d;
  logic                 we_q, we_d;
  logic                 ram_en_q, ram_en_d;
  logic                 ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]    ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]    ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 host_ack_q, host_ack_d;
  logic [NUM_CORES-1:0] core_ack_q, core_ack_d;

  logic                 win_found;
  logic [CW-1:0]        win_idx;
  logic                 win_we;
  logic [ADDR_W-1:0]    win_addr;
  logic [DATA_W-1:0]    win_wdata;

  // Round-robin: lowest requesting index above last, otherwise lowest at or below last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!win_found && core_req[i] && (CW'(i) > last_q)) begin
        win_found = 1'b1;
        win_idx   = CW'(i);
        win_we    = core_we[i];
        win_addr  = core_addr[i*ADDR_W +: ADDR_W];
        win_wdata = core_wdata[i*DATA_W +: DATA_W];
      end
    end
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!win_found && core_req[i] && (CW'(i) <= last_q)) begin
        win_found = 1'b1;
        win_idx   = CW'(i);
        win_we    = core_we[i];
        win_addr  = core_addr[i*ADDR_W +: ADDR_W];
        win_wdata = core_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_id_d    = gnt_id_q;
    gnt_host_d  = gnt_host_q;
    we_d        = we_q;
    ram_en_d    = ram_en_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    rdata_d     = rdata_q;
    host_ack_d  = 1'b0;
    core_ack_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (host_req) begin
          gnt_host_d  = 1'b1;
          we_d        = host_we;
          ram_en_d    = 1'b1;
          ram_we_d    = host_we;
          ram_addr_d  = host_addr;
          ram_wdata_d = host_wdata;
          state_d     = S_ACCESS;
        end else if (!host_lock && win_found) begin
          gnt_host_d  = 1'b0;
          gnt_id_d    = win_idx;
          we_d        = win_we;
          ram_en_d    = 1'b1;
          ram_we_d    = win_we;
          ram_addr_d  = win_addr;
          ram_wdata_d = win_wdata;
          state_d     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        ram_en_d = 1'b0;
        ram_we_d = 1'b0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        // Synchronous RAM: read data is on ram_rdata in the cycle after the strobe.
        if (!we_q) rdata_d = ram_rdata;
        if (gnt_host_q) begin
          host_ack_d = 1'b1;
        end else begin
          for (int i = 0; i < NUM_CORES; i++) core_ack_d[i] = (gnt_id_q == CW'(i));
        end
        state_d = S_DONE;
      end
      default: begin
        if (!gnt_host_q) last_d = gnt_id_q;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      last_q      <= CW'(NUM_CORES - 1);
      gnt_id_q    <= '0;
      gnt_host_q  <= 1'b0;
      we_q        <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rdata_q     <= '0;
      host_ack_q  <= 1'b0;
      core_ack_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_id_q    <= gnt_id_d;
      gnt_host_q  <= gnt_host_d;
      we_q        <= we_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rdata_q     <= rdata_d;
      host_ack_q  <= host_ack_d;
      core_ack_q  <= core_ack_d;
    end
  end

  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign rdata     = rdata_q;
  assign host_ack  = host_ack_q;
  assign core_ack  = core_ack_q;
  assign busy      = (state_q != S_IDLE);

endmodule
